mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one MOV/MOC memory handshake.
// Define MEM_ARBITER_TIMEOUT_EN to abort accesses that see no MOC within TIMEOUT cycles.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        f_req,
  input  logic        f_rw,
  input  logic [31:0] f_addr,
  input  logic [1:0]  f_type,
  input  logic [31:0] f_wdata,
  output logic        f_done,
  output logic        f_err,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_type,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        MOV,
  output logic        RW,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_type,
  output logic [31:0] mem_wdata,
  input  logic        MOC,
  input  logic [31:0] DaOut,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
  state_t state;
  logic last_d;
  logic grant_d;
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be in 1..255");
  end
  // last_d is both the round-robin history and the owner of the access in flight
  assign grant_d = d_req && (!f_req || !last_d);
  assign busy = state != IDLE;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [7:0] cnt;
`else
  assign f_err = 1'b0;
  assign d_err = 1'b0;
`endif
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      MOV       <= 1'b0;
      RW        <= 1'b0;
      mem_addr  <= '0;
      mem_type  <= '0;
      mem_wdata <= '0;
      f_done    <= 1'b0;
      d_done    <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      f_err     <= 1'b0;
      d_err     <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      f_err  <= 1'b0;
      d_err  <= 1'b0;
`endif
      case (state)
        IDLE: if ((f_req || d_req) && !MOC) begin
          state     <= ACCESS;
          last_d    <= grant_d;
          MOV       <= 1'b1;
          RW        <= grant_d ? d_rw : f_rw;
          mem_addr  <= grant_d ? d_addr : f_addr;
          mem_type  <= grant_d ? d_type : f_type;
          mem_wdata <= grant_d ? d_wdata : f_wdata;
`ifdef MEM_ARBITER_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
        ACCESS: if (MOC) begin
          state  <= RELEASE;
          MOV    <= 1'b0;
          f_done <= !last_d;
          d_done <= last_d;
          if (RW && !last_d) f_rdata <= DaOut;
          if (RW && last_d) d_rdata <= DaOut;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (cnt == 8'(TIMEOUT - 1)) begin
          state  <= RELEASE;
          MOV    <= 1'b0;
          f_done <= !last_d;
          d_done <= last_d;
          f_err  <= !last_d;
          d_err  <= last_d;
        end else cnt <= cnt + 8'd1;
`endif
        RELEASE: if (!MOC) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory and a
// request-level arbitration model; expected responses are queued at issue time.
module tb_mem_arbiter;
  localparam int TO = 4;
  logic CLK = 0, CLR = 0;
  logic f_req = 0, f_rw = 0, d_req = 0, d_rw = 0;
  logic [31:0] f_addr = 0, f_wdata = 0, d_addr = 0, d_wdata = 0;
  logic [1:0] f_type = 0, d_type = 0;
  logic f_done, f_err, d_done, d_err, MOV, RW, busy;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0] mem_type;
  logic MOC = 0;
  logic [31:0] DaOut = 0;
  int errs = 0, checks = 0;
  typedef struct {
    logic rw;
    logic [31:0] addr;
    logic [1:0] typ;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic err;
  } txn_t;
  txn_t fq[$], dq[$];
  txn_t cur, px;
  logic grants[$];
  logic [31:0] f_last = 0, d_last = 0, f_hold = 0, d_hold = 0;
  logic last_d_m = 0, g_d = 0, g_cur = 0;
  logic mem_en = 1, exp_abort = 0, rnd_on = 0;
  int lat_fix = -1;
  logic snap_f = 0, snap_d = 0, snap_moc = 0, mov_q = 0;
  int mov_len = 0, last_len = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .CLR(CLR),
    .f_req(f_req), .f_rw(f_rw), .f_addr(f_addr), .f_type(f_type), .f_wdata(f_wdata),
    .f_done(f_done), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_type(d_type), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .MOV(MOV), .RW(RW), .mem_addr(mem_addr), .mem_type(mem_type), .mem_wdata(mem_wdata),
    .MOC(MOC), .DaOut(DaOut), .busy(busy)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h10) ? 32'hE3A01005 : (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected read data is fixed here: a read returns the memory contents, a write or abort leaves rdata alone
  task automatic issue(input logic dp, input logic rw, input logic [31:0] a, input logic [1:0] t, input logic [31:0] w);
    txn_t x;
    x.rw = rw; x.addr = a; x.typ = t; x.wdata = w; x.err = exp_abort;
    if (dp) begin
      if (rw && !exp_abort) d_last = mdata(a);
      x.rdata = d_last;
      dq.push_back(x);
      d_rw = rw; d_addr = a; d_type = t; d_wdata = w; d_req = 1;
    end else begin
      if (rw && !exp_abort) f_last = mdata(a);
      x.rdata = f_last;
      fq.push_back(x);
      f_rw = rw; f_addr = a; f_type = t; f_wdata = w; f_req = 1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((fq.size() != 0 || dq.size() != 0 || busy || MOC) && n < 300) begin
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (n >= 300) begin
      errs++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #2;
    CLR = 0; #1;
    chk("reset_async", {MOV, busy, f_done, d_done, f_rdata, d_rdata}, 0);
    fq.delete(); dq.delete();
    f_req = 0; d_req = 0;
    f_last = 0; d_last = 0; f_hold = 0; d_hold = 0; last_d_m = 0;
    @(posedge CLK); #1;
    CLR = 1;
  endtask

  always @(posedge CLK) begin
    snap_f = f_req; snap_d = d_req; snap_moc = MOC;
  end

  // Memory: answers each strobe after 0..2 cycles, then holds MOC 0..3 extra cycles
  initial forever begin
    @(posedge CLK); #1;
    if (mem_en && CLR && MOV && !MOC) begin
      int d;
      d = (lat_fix >= 0) ? lat_fix : int'($urandom_range(2));
      repeat (d) begin @(posedge CLK); #1; end
      MOC = 1; DaOut = mdata(mem_addr);
      for (int i = 0; i < 20 && MOV; i++) begin @(posedge CLK); #1; end
      repeat ($urandom_range(3)) begin @(posedge CLK); #1; end
      MOC = 0; DaOut = $urandom;
    end
  end

  always @(negedge CLK) begin
    if (!CLR) begin
      mov_q = 0; mov_len = 0;
    end else begin
      if (MOV && !mov_q) begin
        g_d = snap_d && (!snap_f || !last_d_m);
        chk("grant_cond", {snap_f | snap_d, snap_moc}, 2'b10);
        last_d_m = g_d; g_cur = g_d;
        grants.push_back(g_d);
        checks++;
        if ((g_d ? dq.size() : fq.size()) == 0) begin
          errs++;
          $display("FAIL grant_port: granted port %0d has no request, expected %0d", g_d, !g_d);
        end else cur = g_d ? dq[0] : fq[0];
        if (rnd_on && $urandom_range(3) == 0) begin
          if (g_d) begin d_req = 0; d_addr = $urandom; d_wdata = $urandom; d_rw = ~d_rw; end
          else begin f_req = 0; f_addr = $urandom; f_wdata = $urandom; f_rw = ~f_rw; end
        end
      end
      if (MOV) begin
        mov_len++;
        chk("access_hold", {busy, RW, mem_type, mem_addr, mem_wdata}, {1'b1, cur.rw, cur.typ, cur.addr, cur.wdata});
      end else if (mov_q) begin
        last_len = mov_len; mov_len = 0;
      end
      if (f_done) begin
        checks++;
        if (fq.size() == 0) begin
          errs++;
          $display("FAIL f_done: pulse with nothing outstanding, expected no pulse");
        end else begin
          px = fq.pop_front(); f_hold = px.rdata;
          chk("f_done", {g_cur, MOV, busy, f_rdata, f_err}, {1'b0, 1'b0, 1'b1, px.rdata, px.err});
        end
        f_req = 0;
      end else chk("f_idle", {f_rdata, f_err}, {f_hold, 1'b0});
      if (d_done) begin
        checks++;
        if (dq.size() == 0) begin
          errs++;
          $display("FAIL d_done: pulse with nothing outstanding, expected no pulse");
        end else begin
          px = dq.pop_front(); d_hold = px.rdata;
          chk("d_done", {g_cur, MOV, busy, d_rdata, d_err}, {1'b1, 1'b0, 1'b1, px.rdata, px.err});
        end
        d_req = 0;
      end else chk("d_idle", {d_rdata, d_err}, {d_hold, 1'b0});
      mov_q = MOV;
    end
  end

  initial begin
    int n;
    logic [7:0] ord;
    logic [31:0] prev;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ctl", {MOV, RW, busy, f_done, d_done, f_err, d_err, mem_type}, 0);
    chk("reset_data", {mem_addr, mem_wdata, f_rdata, d_rdata}, 0);
    CLR = 1;
    lat_fix = 0;
    issue(0, 1, 32'h10, 2'b10, 32'h0);
    wait_idle();
    chk("fetch_mov_len", last_len, 1);
    chk("fetch_rdata", f_rdata, 32'hE3A01005);
    lat_fix = -1;
    pulse_reset();
    grants.delete();
    issue(0, 1, 32'h100, 2'b10, 32'h0);
    issue(1, 1, 32'h200, 2'b10, 32'h0);
    n = 0;
    while (dq.size() != 0 && n < 50) begin @(posedge CLK); #1; n++; end
    issue(1, 1, 32'h204, 2'b10, 32'h0);
    wait_idle();
    ord = 0;
    foreach (grants[i]) ord = {ord[6:0], grants[i]};
    chk("tie_count", grants.size(), 3);
    chk("tie_order", ord, 8'b101);
    prev = d_last;
    issue(1, 0, 32'h2B, 2'b00, 32'hAA);
    wait_idle();
    chk("write_rdata", d_rdata, prev);
    mem_en = 0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    exp_abort = 1;
    issue(1, 0, 32'h300, 2'b10, 32'h55);
    wait_idle();
    exp_abort = 0;
    chk("timeout_len", last_len, TO);
`else
    issue(1, 0, 32'h300, 2'b10, 32'h55);
    @(posedge CLK); #1;
    n = 0;
    repeat (100) begin @(negedge CLK); if (MOV) n++; end
    chk("stuck_mov", n, 100);
    pulse_reset();
`endif
    issue(0, 1, 32'h400, 2'b10, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    chk("mid_access", {MOV, busy}, 2'b11);
    pulse_reset();
    mem_en = 1;
    issue(0, 1, 32'h400, 2'b10, 32'h0);
    @(posedge CLK); #1;
    chk("grant_after_reset", MOV, 1);
    wait_idle();
    chk("reissue_rdata", f_rdata, mdata(32'h400));
    rnd_on = 1;
    repeat (2500) begin
      @(posedge CLK); #1;
      if (fq.size() == 0 && !f_req && $urandom_range(2) == 0)
        issue(0, 1'($urandom_range(1)), $urandom, 2'($urandom_range(2)), $urandom);
      if (dq.size() == 0 && !d_req && $urandom_range(2) == 0)
        issue(1, 1'($urandom_range(1)), $urandom, 2'($urandom_range(2)), $urandom);
    end
    rnd_on = 0;
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog expired");
  end
endmodule
